rv32m_div_unit: RTL and testbench
=================================

# rv32m_div_unit

Multi-cycle RV32M divide/remainder unit that executes DIV, DIVU, REM and REMU for the datapath's M-extension path. When an R-type instruction has funct7 = 0000001 and funct3[2] = 1, the datapath asserts `start` and holds the PC with `stall` until this unit returns a result. Multiply ops (funct3[2] = 0) stay in the combinational M-ALU and never reach this block. The unit performs radix-2 restoring division, one quotient bit per cycle, and resolves divide-by-zero and signed overflow early.

## Interface
- `WIDTH`, 32, operand and result width; the counter is sized as $clog2(WIDTH)+1 bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  a divide instruction is present. Level; sampled only in IDLE.
- `flush`  in  1  synchronous abort; the unit returns to IDLE and no `done` is produced.
- `funct3`  in  3  operation select: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  WIDTH  dividend (rs1).
- `op_b`  in  WIDTH  divisor (rs2).
- `busy`  out  1  high when state is not IDLE.
- `done`  out  1  single-cycle pulse; `result` is valid while it is high.
- `result`  out  WIDTH  quotient or remainder; holds its last value until the next `done`.
- `stall`  out  1  combinational `start & ~done`; freezes the PC and register writeback.

## Operation
- States:
  - IDLE: wait for `start`.
  - CALC: one restoring step per cycle.
  - FIX: sign correction and result select.
  - DONE: drives `done` = 1, then returns to IDLE unconditionally.
- IDLE, when `start` = 1:
  - Latch funct3 and the operands.
  - Signed ops (funct3[0] = 0) latch |op_a| and |op_b| and record neg_q = sign(a) ^ sign(b) and neg_r = sign(a).
  - If `op_b` = 0, go directly to DONE with:
    - Quotient = all-ones (0xFFFFFFFF).
    - Remainder = op_a, unmodified.
  - If the op is signed, op_a = 0x80000000 and op_b = 0xFFFFFFFF (overflow), go directly to DONE with:
    - Quotient = 0x80000000.
    - Remainder = 0.
  - Otherwise load rem = 0, quo = |a|, cnt = WIDTH, and go to CALC.
- CALC, each cycle:
  - Form {rem, quo} <<= 1 and compute trial = rem − divisor, using WIDTH+1-bit subtraction.
  - If trial ≥ 0: rem = trial and quo[0] = 1.
  - cnt decrements each cycle; at cnt = 1 the next state is FIX.
- FIX:
  - Quotient = neg_q ? −quo : quo.
  - Remainder = neg_r ? −rem : rem.
  - Negation applies to signed ops only, in two's complement modulo 2^WIDTH.
  - Result = funct3[1] ? remainder : quotient, registered into `result`.
  - Next state is DONE.
- `start` while busy is ignored. The datapath holds `start` and operands stable until `done`.
- After DONE the unit sits in IDLE for at least one cycle. The PC advances on the `done` cycle, so a `start` still high in the next cycle belongs to the next instruction.
- `flush` has priority over all transitions except reset. It clears `busy` on the next edge and leaves `result` unchanged.
- `rst_n` low, including mid-operation, asynchronously resets all outputs and registers:
  - state = IDLE.
  - `busy` = 0, `done` = 0.
  - `result` = 0.
  - cnt = 0, rem = 0, quo = 0.

## Timing
- Edge 0 is the edge at which IDLE samples `start` = 1.
- Normal path:
  - CALC occupies edges 1..WIDTH.
  - FIX is entered at edge WIDTH, and `result` is registered at edge WIDTH+1.
  - `done` is high during the cycle after edge WIDTH+1, i.e. latency WIDTH+2 = 34 cycles.
  - `stall` is high for 34 cycles.
- Special cases (divide-by-zero, overflow): `done` is high during the cycle after edge 0, i.e. latency 1 cycle.
- `busy` rises after edge 0 and falls after the DONE cycle.
- `done` is never high in two consecutive cycles.

## Structure
- Shared package `cpu_control_codes` gains:
  - DIV_F3_DIV, DIV_F3_DIVU, DIV_F3_REM, DIV_F3_REMU.
  - Div state encodings: IDLE = 2'b00, CALC = 2'b01, FIX = 2'b10, DONE = 2'b11.
- One natural sub-module, `div_restoring_step`: a combinational single shift-subtract step (inputs rem, quo, divisor; outputs next rem, next quo). The FSM, counter and sign fix-up stay in the top module.

## Test plan
- DIVU 100 / 7 → `done` at cycle 34 with `result` = 14. REMU on the same operands → 2.
- DIV −7 / 2 → 0xFFFFFFFD (−3). REM on the same operands → 0xFFFFFFFF (−1).
- DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 in 1 cycle; REM on the same operands → 0.
- DIV 5 / 0 → 0xFFFFFFFF in 1 cycle. REMU 5 / 0 → 5.
- Pull `rst_n` low at cycle 10 of a DIV → `busy`, `done` and `result` go to 0 immediately; no `done` afterwards. Pulse `flush` at cycle 20 → IDLE next cycle, `result` unchanged.
- Change `op_a` while busy with `start` held → result matches the operands latched at edge 0. Back-to-back `start` → the second op is accepted one cycle after `done`.

Source files
------------

// File: rtl/rv32m_div_unit_pkg.sv
// Shared control codes for the M-extension divide path: funct3 encodings
// and the divide FSM state encoding.
package cpu_control_codes;

  localparam logic [2:0] DIV_F3_DIV  = 3'b100;
  localparam logic [2:0] DIV_F3_DIVU = 3'b101;
  localparam logic [2:0] DIV_F3_REM  = 3'b110;
  localparam logic [2:0] DIV_F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_FIX  = 2'b10,
    DIV_DONE = 2'b11
  } div_state_t;

endpackage

// File: rtl/rv32m_div_unit_restoring_step.sv
// One radix-2 restoring division step: shift {rem, quo} left by one, try to
// subtract the divisor from the widened partial remainder, and keep the
// difference (quotient bit 1) only when it does not go negative.
module div_restoring_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_next_rem,
  output logic [WIDTH-1:0] o_next_quo
);

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_trial;

  // The shifted remainder needs WIDTH+1 bits because rem may be as large as
  // divisor-1 before the shift. When the trial is non-negative the true
  // difference is below the divisor, so the low WIDTH bits are exact.
  always_comb begin
    w_shift    = {i_rem, i_quo[WIDTH-1]};
    w_ge       = (w_shift >= {1'b0, i_divisor});
    w_trial    = w_shift[WIDTH-1:0] - i_divisor;
    o_next_rem = w_ge ? w_trial : w_shift[WIDTH-1:0];
    o_next_quo = {i_quo[WIDTH-2:0], w_ge};
  end

endmodule

// File: rtl/rv32m_div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit. Restoring division, one quotient
// bit per cycle on magnitudes, with sign fix-up at the end. Divide-by-zero
// and signed overflow are resolved in the accepting cycle.
//
// Handshake: i_start is a level held (with operands) by the datapath until
// o_done. It is sampled only in IDLE. o_done is a one-cycle pulse with
// o_result valid during it; o_result then holds until the next o_done.
// i_flush aborts any operation with no o_done and result unchanged.
module rv32m_div_unit
  import cpu_control_codes::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_stall,
  output logic [1:0]       o_state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_sel_rem;

  logic             w_accept;
  logic             w_signed;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_div_zero;
  logic             w_overflow;
  logic [WIDTH-1:0] w_special_res;
  logic [WIDTH-1:0] w_next_rem;
  logic [WIDTH-1:0] w_next_quo;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // Operand decode in IDLE: magnitudes for signed ops and early-out detection.
  always_comb begin
    w_accept   = i_start & i_funct3[2];
    w_signed   = ~i_funct3[0];
    w_abs_a    = (w_signed & i_op_a[WIDTH-1]) ? (~i_op_a + 1'b1) : i_op_a;
    w_abs_b    = (w_signed & i_op_b[WIDTH-1]) ? (~i_op_b + 1'b1) : i_op_b;
    w_div_zero = (i_op_b == '0);
    w_overflow = w_signed & (i_op_a == MOST_NEG) & (&i_op_b);
    if (w_div_zero) begin
      w_special_res = i_funct3[1] ? i_op_a : '1;
    end else begin
      w_special_res = i_funct3[1] ? '0 : MOST_NEG;
    end
  end

  div_restoring_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem      (r_rem),
    .i_quo      (r_quo),
    .i_divisor  (r_divisor),
    .o_next_rem (w_next_rem),
    .o_next_quo (w_next_quo)
  );

  // Sign fix-up; the neg flags are only ever set for signed ops.
  always_comb begin
    w_quo_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    w_rem_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;
  end

  // Divide FSM with registered busy/done/result; flush overrides every transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= DIV_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_sel_rem <= 1'b0;
    end else if (i_flush) begin
      r_state <= DIV_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_busy    <= 1'b1;
            r_sel_rem <= i_funct3[1];
            r_neg_q   <= w_signed & (i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1]);
            r_neg_r   <= w_signed & i_op_a[WIDTH-1];
            r_divisor <= w_abs_b;
            if (w_div_zero || w_overflow) begin
              r_result <= w_special_res;
              r_done   <= 1'b1;
              r_state  <= DIV_DONE;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_abs_a;
              r_cnt   <= CW'(WIDTH);
              r_state <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          r_rem <= w_next_rem;
          r_quo <= w_next_quo;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          r_result <= r_sel_rem ? w_rem_fix : w_quo_fix;
          r_done   <= 1'b1;
          r_state  <= DIV_DONE;
        end
        DIV_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= DIV_IDLE;
        end
        default: begin
          r_state <= DIV_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_stall  = i_start & ~r_done;
  assign o_state  = r_state;

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Directed bench for rv32m_div_unit: hand-computed quotient/remainder
// vectors, latency and stall length, reset and flush aborts, operand
// changes while busy, and back-to-back starts.
module tb_rv32m_div_unit;
  import cpu_control_codes::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         i_start;
  logic         i_flush;
  logic [2:0]   i_funct3;
  logic [W-1:0] i_op_a;
  logic [W-1:0] i_op_b;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_result;
  logic         o_stall;
  logic [1:0]   o_state;

  int n_vec  = 0;
  int n_miss = 0;

  logic [W-1:0] exp_q[$];

  rv32m_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (i_start),
    .i_flush  (i_flush),
    .i_funct3 (i_funct3),
    .i_op_a   (i_op_a),
    .i_op_b   (i_op_b),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result),
    .o_stall  (o_stall),
    .o_state  (o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one op from a negedge, wait for done, and score result, latency
  // (negedges until done is seen) and the number of cycles stall was high.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input int exp_lat,
                        input int exp_stall, input bit perturb,
                        input bit keep_start);
    int lat;
    int stall_cnt;
    bit got;
    logic [W-1:0] exp_v;
    exp_q.push_back(exp_res);
    i_funct3 = f3;
    i_op_a   = a;
    i_op_b   = b;
    i_start  = 1'b1;
    #1;
    stall_cnt = int'(o_stall);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (perturb && lat == 5) begin
        i_op_a = ~a;
        i_op_b = b + 32'd3;
      end
      if (o_done) got = 1'b1;
      else stall_cnt += int'(o_stall);
    end
    exp_v = exp_q.pop_front();
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_result"}, o_result, exp_v);
      check({tag, "_latency"}, W'(lat), W'(exp_lat));
      check({tag, "_stall"}, W'(stall_cnt), W'(exp_stall));
    end
    if (!keep_start) begin
      i_start = 1'b0;
      @(negedge clk);
      check({tag, "_done_drop"}, W'(o_done), 32'd0);
      check({tag, "_busy_drop"}, W'(o_busy), 32'd0);
    end
  endtask

  // Watch a window of cycles and report how many done pulses appear.
  task automatic expect_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (o_done) seen++;
    end
    check(tag, W'(seen), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    i_start  = 1'b0;
    i_flush  = 1'b0;
    i_funct3 = DIV_F3_DIV;
    i_op_a   = '0;
    i_op_b   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", W'(o_busy), 32'd0);
    check("rst_done", W'(o_done), 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_stall", W'(o_stall), 32'd0);
    check("rst_state", W'(o_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("divu_100_7", DIV_F3_DIVU, 32'd100, 32'd7, 32'd14, 34, 34, 1'b0, 1'b0);
    run_op("remu_100_7", DIV_F3_REMU, 32'd100, 32'd7, 32'd2, 34, 34, 1'b0, 1'b0);
    run_op("div_m7_2", DIV_F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 34, 1'b0, 1'b0);
    run_op("rem_m7_2", DIV_F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 34, 1'b0, 1'b0);
    run_op("div_7_m2", DIV_F3_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 34, 1'b0, 1'b0);
    run_op("rem_7_m2", DIV_F3_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 34, 1'b0, 1'b0);
    run_op("divu_max_2", DIV_F3_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 34, 34, 1'b0, 1'b0);
    run_op("divu_min_max", DIV_F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 34, 1'b0, 1'b0);
    run_op("remu_min_max", DIV_F3_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 34, 1'b0, 1'b0);
    run_op("div_min_1", DIV_F3_DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, 34, 34, 1'b0, 1'b0);
    run_op("div_ovf", DIV_F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1, 1'b0, 1'b0);
    run_op("rem_ovf", DIV_F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1, 1'b0, 1'b0);
    run_op("div_5_0", DIV_F3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1, 1'b0, 1'b0);
    run_op("remu_5_0", DIV_F3_REMU, 32'd5, 32'd0, 32'd5, 1, 1, 1'b0, 1'b0);
    run_op("rem_m7_0", DIV_F3_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, 1, 1'b0, 1'b0);

    // operands change while busy: result follows the values latched at accept
    run_op("divu_perturb", DIV_F3_DIVU, 32'd1000, 32'd10, 32'd100, 34, 34, 1'b1, 1'b0);

    // back-to-back: start stays high; second op is sampled after one IDLE cycle
    run_op("b2b_first", DIV_F3_DIVU, 32'd50, 32'd5, 32'd10, 34, 34, 1'b0, 1'b1);
    run_op("b2b_second", DIV_F3_REMU, 32'd50, 32'd7, 32'd1, 35, 34, 1'b0, 1'b0);

    // asynchronous reset in the middle of a DIV
    i_funct3 = DIV_F3_DIV;
    i_op_a   = 32'd100;
    i_op_b   = 32'd7;
    i_start  = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", W'(o_busy), 32'd0);
    check("mid_rst_done", W'(o_done), 32'd0);
    check("mid_rst_result", o_result, 32'd0);
    check("mid_rst_state", W'(o_state), 32'd0);
    i_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_no_done("mid_rst_no_done", 40);

    // establish a known result, then flush a DIV partway through
    run_op("divu_9_3", DIV_F3_DIVU, 32'd9, 32'd3, 32'd3, 34, 34, 1'b0, 1'b0);
    i_funct3 = DIV_F3_DIV;
    i_op_a   = 32'd100;
    i_op_b   = 32'd7;
    i_start  = 1'b1;
    repeat (20) @(negedge clk);
    check("pre_flush_busy", W'(o_busy), 32'd1);
    i_flush = 1'b1;
    i_start = 1'b0;
    @(negedge clk);
    i_flush = 1'b0;
    check("flush_busy", W'(o_busy), 32'd0);
    check("flush_state", W'(o_state), 32'd0);
    check("flush_result", o_result, 32'd3);
    expect_no_done("flush_no_done", 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
